// File: rtl/pixel_stream_writer.sv
// Byte-stream to framebuffer writer: packs RGB byte triples into 24-bit pixel words
// and writes them sequentially into the panel framebuffer write port.
module pixel_stream_writer #(
    parameter int unsigned MATRIX_COLS = 64,
    parameter int unsigned MATRIX_ROWS = 32,
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned DATA_WIDTH  = 24
) (
    input  logic                  i_clk,
    input  logic                  rst_n,
    input  logic                  i_sof,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_din,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_sof_abort
);

    localparam int unsigned Pixels = MATRIX_COLS * MATRIX_ROWS;
    // Explicit wrap point so panels whose pixel count is not a power of two work.
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(Pixels - 1);

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            phase_q, phase_d;
    logic [15:0]           shift_q, shift_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;
    logic                  hs;

    assign o_byte_ready = (state_q == StLoad) && !i_sof;
    assign hs           = i_byte_valid && o_byte_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        shift_d = shift_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_sof) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    phase_d = 2'd0;
                end
            end
            StLoad: begin
                if (i_sof) begin
                    // Restart the frame; partial pixel is dropped, not written.
                    abort_d = (cnt_q != '0) || (phase_q != 2'd0);
                    cnt_d   = '0;
                    phase_d = 2'd0;
                end else if (hs) begin
                    unique case (phase_q)
                        2'd0: begin
                            shift_d[15:8] = i_byte;
                            phase_d       = 2'd1;
                        end
                        2'd1: begin
                            shift_d[7:0] = i_byte;
                            phase_d      = 2'd2;
                        end
                        default: begin
                            we_d    = 1'b1;
                            addr_d  = cnt_q;
                            din_d   = DATA_WIDTH'({shift_q, i_byte});
                            phase_d = 2'd0;
                            if (cnt_q == LastAddr) begin
                                cnt_d   = '0;
                                state_d = StIdle;
                                done_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + ADDR_WIDTH'(1);
                            end
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            phase_q <= 2'd0;
            shift_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign o_ram_we     = we_q;
    assign o_ram_addr   = addr_q;
    assign o_ram_din    = din_q;
    assign o_busy       = (state_q == StLoad);
    assign o_frame_done = done_q;
    assign o_sof_abort  = abort_q;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Directed bench for pixel_stream_writer: a small byte-assembly model predicts every
// framebuffer write, handshake and pulse; a negedge monitor compares against the DUT.
module tb_pixel_stream_writer;

    localparam int unsigned Pixels = 64 * 32;

    logic        clk;
    logic        rst_n;
    logic        i_sof;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        o_ram_we;
    logic [10:0] o_ram_addr;
    logic [23:0] o_ram_din;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_sof_abort;

    pixel_stream_writer #(
        .MATRIX_COLS(64),
        .MATRIX_ROWS(32),
        .ADDR_WIDTH (11),
        .DATA_WIDTH (24)
    ) dut (
        .i_clk       (clk),
        .rst_n       (rst_n),
        .i_sof       (i_sof),
        .i_byte      (i_byte),
        .i_byte_valid(i_byte_valid),
        .o_byte_ready(o_byte_ready),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_din   (o_ram_din),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done),
        .o_sof_abort (o_sof_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] addr;
        logic [23:0] din;
        logic        done;
    } wr_t;

    wr_t         exp_q[$];
    int          nvec = 0;
    int          nerr = 0;
    int          nwr  = 0;
    int          wr_base;
    bit          mon_en = 1'b0;
    bit          m_load = 1'b0;
    bit          m_load_n = 1'b0;
    bit          abort_exp = 1'b0;
    bit          abort_n = 1'b0;
    int          m_cnt = 0;
    int          m_phase = 0;
    logic [23:0] m_pix = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change and model state commits 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        m_load    = m_load_n;
        abort_exp = abort_n;
        abort_n   = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        i_sof        = 1'b0;
        i_byte       = b;
        i_byte_valid = 1'b1;
        #1;
        check("ready", {31'd0, o_byte_ready}, {31'd0, m_load});
        if (m_load) begin
            case (m_phase)
                0: m_pix[23:16] = b;
                1: m_pix[15:8]  = b;
                default: begin
                    m_pix[7:0] = b;
                    exp_q.push_back('{addr: 11'(m_cnt), din: m_pix,
                                      done: (m_cnt == Pixels - 1)});
                    if (m_cnt == Pixels - 1) begin
                        m_cnt    = 0;
                        m_load_n = 1'b0;
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
            m_phase = (m_phase + 1) % 3;
        end
        tick();
        i_byte_valid = 1'b0;
    endtask

    task automatic sof(input bit with_byte, input logic [7:0] b);
        i_sof        = 1'b1;
        i_byte_valid = with_byte;
        i_byte       = b;
        #1;
        check("ready_sof", {31'd0, o_byte_ready}, 32'd0);
        abort_n  = m_load && (m_cnt != 0 || m_phase != 0);
        m_load_n = 1'b1;
        m_cnt    = 0;
        m_phase  = 0;
        tick();
        i_sof        = 1'b0;
        i_byte_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", {31'd0, o_busy}, {31'd0, m_load});
            check("abort", {31'd0, o_sof_abort}, {31'd0, abort_exp});
            if (o_ram_we) begin
                wr_t e;
                nwr++;
                if (exp_q.size() == 0) begin
                    check("unexp_we", {31'd0, o_ram_we}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", {21'd0, o_ram_addr}, {21'd0, e.addr});
                    check("din", {8'd0, o_ram_din}, {8'd0, e.din});
                    check("done", {31'd0, o_frame_done}, {31'd0, e.done});
                end
            end else begin
                check("done_no_we", {31'd0, o_frame_done}, 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, {31'd0, o_ram_we}, 32'd0);
        check({tag, "_addr"}, {21'd0, o_ram_addr}, 32'd0);
        check({tag, "_din"}, {8'd0, o_ram_din}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_ready"}, {31'd0, o_byte_ready}, 32'd0);
        check({tag, "_done"}, {31'd0, o_frame_done}, 32'd0);
        check({tag, "_abort"}, {31'd0, o_sof_abort}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        i_sof        = 1'b0;
        i_byte       = 8'h5A;
        i_byte_valid = 1'b1;
        repeat (3) tick();
        check_all_zero("rst");
        rst_n        = 1'b1;
        i_byte_valid = 1'b0;
        mon_en       = 1'b1;
        tick();

        // Bytes without a preceding start-of-frame are never accepted.
        wr_base = nwr;
        for (int i = 0; i < 10; i++) put(8'(i + 1));
        tick();
        check("idle_writes", nwr - wr_base, 0);

        // Single pixel, then hold of address/data once the write pulse ends.
        sof(1'b0, 8'h00);
        put(8'h12);
        put(8'h34);
        put(8'h56);
        tick();
        tick();
        check("hold_we", {31'd0, o_ram_we}, 32'd0);
        check("hold_addr", {21'd0, o_ram_addr}, 32'd0);
        check("hold_din", {8'd0, o_ram_din}, 32'h123456);
        check("single_drain", exp_q.size(), 0);

        // Abort mid-pixel with a byte offered in the sof cycle.
        sof(1'b0, 8'h00);
        put(8'hAA);
        put(8'hBB);
        sof(1'b1, 8'hCC);
        put(8'h01);
        put(8'h02);
        put(8'h03);
        tick();
        tick();
        check("abort_drain", exp_q.size(), 0);

        // Full frame with random valid gaps.
        sof(1'b0, 8'h00);
        wr_base = nwr;
        for (int i = 0; i < 3 * Pixels; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            put(8'(i * 7 + 3));
        end
        tick();
        tick();
        check("frame1_writes", nwr - wr_base, Pixels);
        put(8'hEE);
        put(8'hEF);

        // Continuous frame, next frame started in the frame-done cycle.
        sof(1'b0, 8'h00);
        wr_base = nwr;
        for (int i = 0; i < 3 * Pixels; i++) put(8'(i * 13 + 5));
        sof(1'b0, 8'h00);
        for (int i = 0; i < 300; i++) put(8'(i * 11 + 1));
        check("frame2_writes", nwr - wr_base, Pixels + 99);

        // Asynchronous reset between edges after 100 pixels of the third frame.
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_load   = 1'b0;
        m_load_n = 1'b0;
        m_cnt    = 0;
        m_phase  = 0;
        abort_exp = 1'b0;
        abort_n  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();
        wr_base = nwr;
        for (int i = 0; i < 6; i++) put(8'(i + 40));
        check("post_rst_ignored", nwr - wr_base, 0);
        sof(1'b0, 8'h00);
        put(8'h9A);
        put(8'hBC);
        put(8'hDE);
        tick();
        tick();
        check("post_rst_writes", nwr - wr_base, 1);
        check("final_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
